// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache geometry, fetch address split and controller states.
package cpu_types_pkg;

    localparam int unsigned ICACHE_SETS  = 16;
    localparam int unsigned ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int unsigned ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: combinational read port, synchronous write port, synchronous clear.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter  int unsigned SETS  = ICACHE_SETS,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned TAG_W = 30 - IDX_W
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [IDX_W-1:0] ridx,
    output logic             rvalid,
    output logic [TAG_W-1:0] rtag,
    output logic [31:0]      rdata,
    input  logic             wen,
    input  logic [IDX_W-1:0] widx,
    input  logic [TAG_W-1:0] wtag,
    input  logic [31:0]      wdata
);

    logic             valid_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS];
    logic [31:0]      data_q  [SETS];

    // Clear has priority over a same-cycle write so a flush beats a completing fill.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < int'(SETS); i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else if (wen) begin
            valid_q[widx] <= 1'b1;
            tag_q[widx]   <= wtag;
            data_q[widx]  <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: zero-latency hits, single-word blocking fill on a miss.
module icache_responder
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    icache_state_t           state, next_state;
    icachef_t                req, miss_q;
    logic                    miss_latch;
    logic                    fill_wen;
    logic                    rd_valid;
    logic [ICACHE_TAG_W-1:0] rd_tag;
    logic [31:0]             rd_data;
    logic                    lookup_hit;
    logic                    unused_bytoff;

    assign req           = imemaddr;
    assign unused_bytoff = ^req.bytoff;
    assign lookup_hit    = rd_valid && (rd_tag == req.tag);

    icache_frame_array #(
        .SETS (ICACHE_SETS)
    ) u_frames (
        .clk    (CLK),
        .clear  (RST | iflush),
        .ridx   (req.idx),
        .rvalid (rd_valid),
        .rtag   (rd_tag),
        .rdata  (rd_data),
        .wen    (fill_wen),
        .widx   (miss_q.idx),
        .wtag   (miss_q.tag),
        .wdata  (iload)
    );

    // State and miss address; byte offset is stored as zero so iaddr is word aligned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            miss_q <= '0;
        end else begin
            state <= next_state;
            if (miss_latch) begin
                miss_q <= '{tag: req.tag, idx: req.idx, bytoff: 2'b00};
            end
        end
    end

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        imemload   = 32'h0;
        iREN       = 1'b0;
        iaddr      = 32'h0;
        miss_latch = 1'b0;
        fill_wen   = 1'b0;
        case (state)
            IDLE: begin
                if (imemREN && !iflush) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = rd_data;
                    end else begin
                        miss_latch = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_q;
                if (!iwait) begin
                    fill_wen   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios then random fetches against a slot-level cache model.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iflush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks = 0;
    int errors = 0;

    // Model: per slot, whether it holds a word, which word address it holds, and the data.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];

    icache_responder dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .iflush   (iflush),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch of address a; on a miss the memory answers after lat busy cycles with d.
    // fmode: 0 none, 1 flush on first busy cycle, 2 flush on completion cycle.
    task automatic fetch(input logic [31:0] a, input int lat, input logic [31:0] d,
                         input int fmode, input logic [31:0] mid_addr);
        int slot;
        bit h;
        slot     = int'((a >> 2) % 16);
        imemREN  = 1'b1;
        imemaddr = a;
        iflush   = 1'b0;
        iwait    = 1'b1;
        iload    = $urandom;
        #1;
        h = m_valid[slot] && (m_word[slot] == a[31:2]);
        chk("lookup_ihit", 32'(ihit), 32'(h));
        chk("lookup_data", imemload, h ? m_data[slot] : 32'h0);
        chk("lookup_iren", 32'(iREN), 32'h0);
        tick();
        if (!h) begin
            for (int c = 0; c <= lat; c++) begin
                iwait    = (c < lat);
                iflush   = (fmode == 1 && c == 0 && lat > 0) || (fmode == 2 && c == lat);
                iload    = (c == lat) ? d : $urandom;
                imemaddr = mid_addr;
                imemREN  = 1'($urandom_range(0, 1));
                #1;
                chk("fill_iren", 32'(iREN), 32'h1);
                chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
                chk("fill_ihit", 32'(ihit), 32'h0);
                chk("fill_load", imemload, 32'h0);
                tick();
                if (c == lat) begin
                    m_valid[slot] = 1'b1;
                    m_word[slot]  = a[31:2];
                    m_data[slot]  = d;
                end
                if (iflush) m_clear();
            end
        end
        imemREN = 1'b0;
        iflush  = 1'b0;
        iwait   = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        iflush   = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        m_clear();
        tick();
        tick();
        RST = 1'b0;
        #1;
        chk("rst_ihit", 32'(ihit), 32'h0);
        chk("rst_load", imemload, 32'h0);
        chk("rst_iren", 32'(iREN), 32'h0);
        chk("rst_iaddr", iaddr, 32'h0);

        // Cold miss, then hits with a nonzero byte offset.
        fetch(32'h0000_0040, 3, 32'h2008_0005, 0, 32'h0000_0040);
        fetch(32'h0000_0040, 0, 32'h0, 0, 32'h0);
        fetch(32'h0000_0043, 0, 32'h0, 0, 32'h0);

        // Conflict eviction on slot 0.
        fetch(32'h0000_0440, 2, 32'hDEAD_BEEF, 0, 32'h0000_0440);
        fetch(32'h0000_0040, 1, 32'h2008_0005, 0, 32'h0000_0040);

        // Address moves mid-fill; the new address is looked up afterwards.
        fetch(32'h0000_0080, 2, 32'h1111_2222, 0, 32'h0000_0084);
        fetch(32'h0000_0084, 1, 32'h3333_4444, 0, 32'h0000_0084);
        fetch(32'h0000_0080, 0, 32'h0, 0, 32'h0);

        // Flush while a valid address is requested.
        fetch(32'h0000_0040, 1, 32'h2008_0005, 0, 32'h0000_0040);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        iflush   = 1'b1;
        #1;
        chk("flush_ihit", 32'(ihit), 32'h0);
        chk("flush_load", imemload, 32'h0);
        chk("flush_iren", 32'(iREN), 32'h0);
        tick();
        m_clear();
        iflush  = 1'b0;
        imemREN = 1'b0;
        #1;
        chk("flush_no_miss", 32'(iREN), 32'h0);
        fetch(32'h0000_0040, 1, 32'h5555_6666, 2, 32'h0000_0040);
        fetch(32'h0000_0040, 2, 32'h7777_8888, 1, 32'h0000_0040);
        fetch(32'h0000_0040, 0, 32'h0, 0, 32'h0);

        // Reset in the middle of a fill.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0100;
        #1;
        chk("rstfill_miss", 32'(ihit), 32'h0);
        tick();
        chk("rstfill_iren", 32'(iREN), 32'h1);
        imemREN = 1'b0;
        RST     = 1'b1;
        iwait   = 1'b1;
        tick();
        RST = 1'b0;
        m_clear();
        #1;
        chk("rstfill_iren_after", 32'(iREN), 32'h0);
        chk("rstfill_iaddr_after", iaddr, 32'h0);
        fetch(32'h0000_0100, 1, 32'h9999_AAAA, 0, 32'h0000_0100);

        // Random fetches over a few tags per slot so hits, conflicts and flushes mix.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                imemREN  = 1'b0;
                imemaddr = $urandom;
                iflush   = 1'($urandom_range(0, 1));
                #1;
                chk("idle_ihit", 32'(ihit), 32'h0);
                chk("idle_iren", 32'(iREN), 32'h0);
                tick();
                if (iflush) m_clear();
                iflush = 1'b0;
                #1;
                chk("idle_stays", 32'(iREN), 32'h0);
            end else begin
                a = 32'($urandom_range(0, 3)) << 6 | 32'($urandom_range(0, 15)) << 2
                    | 32'($urandom_range(0, 3));
                fetch(a, $urandom_range(0, 3), $urandom, $urandom_range(0, 6), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
